// File: rtl/data_mem_ctrl.sv
// Load/store unit between the single-cycle datapath and a req/ack data bus.
// Stalls the core while an access is outstanding; flags misaligned and timed-out accesses.
module data_mem_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        mem_write,
  input  logic        byte_acc,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {StIdle, StBus, StResp} state_e;

  // Counter value seen during the last BUS cycle before giving up.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        byte_q, byte_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [29:0] baddr_q, baddr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] bwdata_q, bwdata_d;
  logic [7:0]  lane;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      byte_q   <= 1'b0;
      off_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      baddr_q  <= '0;
      be_q     <= '0;
      bwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      off_q    <= off_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      we_q     <= we_d;
      baddr_q  <= baddr_d;
      be_q     <= be_d;
      bwdata_q <= bwdata_d;
    end
  end

  always_comb begin
    lane = bus_rdata[7:0];
    unique case (off_q)
      2'd0: lane = bus_rdata[7:0];
      2'd1: lane = bus_rdata[15:8];
      2'd2: lane = bus_rdata[23:16];
      2'd3: lane = bus_rdata[31:24];
      default: lane = bus_rdata[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    off_d    = off_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    we_d     = we_q;
    baddr_d  = baddr_q;
    be_d     = be_q;
    bwdata_d = bwdata_q;
    stall    = 1'b0;

    unique case (state_q)
      StIdle: begin
        stall = req_valid;
        if (req_valid) begin
          err_d = 1'b0;
          if (!byte_acc && (addr[1:0] != 2'b00)) begin
            state_d = StResp;
            err_d   = 1'b1;
            rdata_d = ERR_RDATA;
          end else begin
            state_d  = StBus;
            cnt_d    = '0;
            byte_d   = byte_acc;
            off_d    = addr[1:0];
            we_d     = mem_write;
            baddr_d  = addr[31:2];
            be_d     = byte_acc ? (4'b0001 << addr[1:0]) : 4'b1111;
            bwdata_d = byte_acc ? {4{wdata[7:0]}} : wdata;
          end
        end
      end
      StBus: begin
        stall = 1'b1;
        cnt_d = cnt_q + 8'd1;
        // A late ack on the final cycle still wins over the timeout.
        if (bus_ack) begin
          state_d = StResp;
          err_d   = 1'b0;
          if (!we_q) rdata_d = byte_q ? {24'h0, lane} : bus_rdata;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StResp;
          err_d   = 1'b1;
          rdata_d = ERR_RDATA;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign bus_req   = (state_q == StBus);
  assign bus_we    = we_q;
  assign bus_addr  = baddr_q;
  assign bus_be    = be_q;
  assign bus_wdata = bwdata_q;
  assign rdata     = rdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed self-checking bench for data_mem_ctrl (TIMEOUT shortened to 4).
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        mem_write = 1'b0;
  logic        byte_acc = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_checks = 0;
  int n_fail = 0;

  data_mem_ctrl #(.TIMEOUT(4), .ERR_RDATA(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .mem_write(mem_write),
    .byte_acc(byte_acc), .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall),
    .err(err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic bt, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1;
    mem_write = we;
    byte_acc  = bt;
    addr      = a;
    wdata     = d;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL rst_bus_req got %b want 0", bus_req); end
    n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL rst_bus_we got %b want 0", bus_we); end
    n_checks++; if ({bus_addr, bus_be, bus_wdata} !== 66'h0) begin n_fail++; $display("FAIL rst_bus_fields got %h/%h/%h want 0", bus_addr, bus_be, bus_wdata); end
    n_checks++; if ({rdata, err} !== 33'h0) begin n_fail++; $display("FAIL rst_rdata_err got %h/%b want 0/0", rdata, err); end
    req_valid = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall_follows got %b want 1", stall); end
    req_valid = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_idle got %b want 0", stall); end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_word_load();
    int stall_cycles = 0;
    issue(1'b0, 1'b0, 32'h0000_0104, 32'h0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL wl_stall_accept got %b want 1", stall); end
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL wl_req_idle got %b want 0", bus_req); end
    stall_cycles += stall;
    tick();
    addr = 32'hFFFF_FFF0;
    #1;
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL wl_req got %b want 1", bus_req); end
    n_checks++; if (bus_addr !== 30'h41) begin n_fail++; $display("FAIL wl_bus_addr got %h want 41", bus_addr); end
    n_checks++; if (bus_be !== 4'hF) begin n_fail++; $display("FAIL wl_bus_be got %h want f", bus_be); end
    n_checks++; if (bus_we !== 1'b0) begin n_fail++; $display("FAIL wl_bus_we got %b want 0", bus_we); end
    stall_cycles += stall;
    tick();
    bus_ack = 1'b1;
    bus_rdata = 32'hCAFE_F00D;
    n_checks++; if (bus_addr !== 30'h41) begin n_fail++; $display("FAIL wl_addr_held got %h want 41", bus_addr); end
    stall_cycles += stall;
    tick();
    bus_ack = 1'b0;
    bus_rdata = 32'h0;
    n_checks++; if (stall_cycles != 3) begin n_fail++; $display("FAIL wl_stall_cycles got %0d want 3", stall_cycles); end
    n_checks++; if (stall !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL wl_resp got stall=%b req=%b want 0/0", stall, bus_req); end
    n_checks++; if (rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL wl_rdata got %h want cafef00d", rdata); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL wl_err got %b want 0", err); end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_byte_store();
    issue(1'b1, 1'b1, 32'h0000_0203, 32'h1234_56AB);
    tick();
    n_checks++; if (bus_be !== 4'b1000) begin n_fail++; $display("FAIL bs_bus_be got %b want 1000", bus_be); end
    n_checks++; if (bus_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL bs_wdata got %h want abababab", bus_wdata); end
    n_checks++; if (bus_we !== 1'b1) begin n_fail++; $display("FAIL bs_we got %b want 1", bus_we); end
    n_checks++; if (bus_addr !== 30'h80) begin n_fail++; $display("FAIL bs_addr got %h want 80", bus_addr); end
    bus_ack = 1'b1;
    bus_rdata = 32'h5555_5555;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (rdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL bs_rdata_kept got %h want cafef00d", rdata); end
    n_checks++; if (err !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL bs_resp got err=%b stall=%b want 0/0", err, stall); end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_byte_load();
    issue(1'b0, 1'b1, 32'h0000_0012, 32'h0);
    tick();
    addr = 32'h0000_0011;
    n_checks++; if (bus_be !== 4'b0100 || bus_addr !== 30'h4) begin n_fail++; $display("FAIL bl_lane got be=%b addr=%h want 0100/4", bus_be, bus_addr); end
    bus_ack = 1'b1;
    bus_rdata = 32'h8877_6655;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (rdata !== 32'h0000_0077) begin n_fail++; $display("FAIL bl_rdata got %h want 00000077", rdata); end
    req_valid = 1'b0;
    tick();
    // Stray ack while idle must not disturb the result.
    bus_ack = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    bus_ack = 1'b0;
    tick();
    n_checks++; if (rdata !== 32'h0000_0077 || err !== 1'b0) begin n_fail++; $display("FAIL idle_ack got %h/%b want 00000077/0", rdata, err); end
  endtask

  task automatic test_misaligned();
    issue(1'b1, 1'b0, 32'h0000_0006, 32'h1111_2222);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mis_stall got %b want 1", stall); end
    tick();
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL mis_req got %b want 0", bus_req); end
    n_checks++; if (err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL mis_resp got %b/%h want 1/0", err, rdata); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mis_stall_resp got %b want 0", stall); end
    req_valid = 1'b0;
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL mis_err_hold got %b want 1", err); end
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    bit done = 0;
    issue(1'b0, 1'b0, 32'h0000_0040, 32'h0);
    for (int i = 0; i < 10 && !done; i++) begin
      tick();
      if (bus_req === 1'b1) req_cycles++;
      if (stall === 1'b0) done = 1;
    end
    n_checks++; if (!done) begin n_fail++; $display("FAIL to_bound got running want resp within 10 cycles"); end
    n_checks++; if (req_cycles != 4) begin n_fail++; $display("FAIL to_req_cycles got %0d want 4", req_cycles); end
    n_checks++; if (err !== 1'b1 || rdata !== 32'h0) begin n_fail++; $display("FAIL to_resp got %b/%h want 1/0", err, rdata); end
    req_valid = 1'b0;
    tick();
    issue(1'b0, 1'b0, 32'h0000_0044, 32'h0);
    tick();
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_err_clear got %b want 0", err); end
    bus_ack = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (rdata !== 32'h0BAD_F00D || err !== 1'b0) begin n_fail++; $display("FAIL to_recover got %h/%b want 0badf00d/0", rdata, err); end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_ack_at_timeout();
    issue(1'b0, 1'b0, 32'h0000_0080, 32'h0);
    tick();
    tick();
    tick();
    tick();
    n_checks++; if (bus_req !== 1'b1) begin n_fail++; $display("FAIL at_req_last got %b want 1", bus_req); end
    bus_ack = 1'b1;
    bus_rdata = 32'h1357_9BDF;
    tick();
    bus_ack = 1'b0;
    n_checks++; if (err !== 1'b0 || rdata !== 32'h1357_9BDF) begin n_fail++; $display("FAIL at_priority got %b/%h want 0/13579bdf", err, rdata); end
    req_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_bus();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    issue(1'b0, 1'b0, 32'h0000_0100, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    n_checks++; if (bus_req !== 1'b0) begin n_fail++; $display("FAIL mr_req got %b want 0", bus_req); end
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mr_stall got %b want 1", stall); end
    req_valid = 1'b0;
    tick();
    rst = 1'b1;
    bus_ack = 1'b1;
    bus_rdata = 32'hFEED_FACE;
    tick();
    bus_ack = 1'b0;
    tick();
    n_checks++; if (rdata !== 32'h0 || err !== 1'b0 || bus_req !== 1'b0) begin n_fail++; $display("FAIL mr_stale_ack got %h/%b/%b want 0/0/0", rdata, err, bus_req); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid_bus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
